run_sequencer: RTL and testbench

Run controller for the single-cycle processor core. It owns the core's reset line and sequences one program run per request: it holds the core in reset while idle, primes it, lets it execute, and detects the halt address on the program counter. It then reports `done` with a run-length cycle count. It sits between the bench-facing `req`/`done` pins and the core's PC, flag registers and register file reset.

---
 rtl/run_seq_pkg.sv | 59 +++++
 rtl/run_sequencer.sv | 117 +++++++++++
 tb/tb_run_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and constants for the run sequencer: the FSM state
// encoding, the registered output bundle and its Moore decode.
package run_seq_pkg;

    // Width of the prime (core reset hold) counter; RST_CYCLES must fit.
    localparam int PRIME_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } run_state_e;

    typedef struct packed {
        logic core_reset;
        logic busy;
        logic done;
        logic timeout;
    } seq_out_t;

    // Moore output decode for a given state; unknown encodings fall back
    // to the safe "core held in reset, nothing reported" pattern.
    function automatic seq_out_t moore_out(input run_state_e s);
        seq_out_t o;
        o.core_reset = 1'b1;
        o.busy       = 1'b0;
        o.done       = 1'b0;
        o.timeout    = 1'b0;
        case (s)
            ST_IDLE: begin
                o.core_reset = 1'b1;
            end
            ST_PRIME: begin
                o.core_reset = 1'b1;
                o.busy       = 1'b1;
            end
            ST_RUN: begin
                o.core_reset = 1'b0;
                o.busy       = 1'b1;
            end
            ST_DONE: begin
                o.core_reset = 1'b1;
                o.done       = 1'b1;
            end
            ST_FAULT: begin
                o.core_reset = 1'b1;
                o.done       = 1'b1;
                o.timeout    = 1'b1;
            end
            default: begin
                o.core_reset = 1'b1;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/run_sequencer.sv
// Run controller for the single-cycle core: holds the core in reset while
// idle, primes it for RST_CYCLES cycles, lets it run until the PC reaches
// HALT_PC, then reports done with the number of RUN cycles.
// Optional feature: define RUN_WATCHDOG_EN to abort runs that reach
// WD_LIMIT cycles without halting (FAULT state, timeout output).
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int D          = 12,
    parameter int HALT_PC    = 128,
    parameter int RST_CYCLES = 2,
    parameter int CW         = 16,
    parameter int WD_LIMIT   = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [D-1:0]  prog_ctr,
    output logic          core_reset,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_cnt
);

`ifdef RUN_WATCHDOG_EN
    localparam logic WD_EN = 1'b1;
`else
    localparam logic WD_EN = 1'b0;
`endif

    localparam logic [D-1:0]       HALT_VAL   = D'(HALT_PC);
    localparam logic [PRIME_W-1:0] PRIME_LOAD = PRIME_W'(RST_CYCLES - 1);
    localparam logic [CW-1:0]      WD_LAST    = CW'(WD_LIMIT - 1);
    localparam logic [CW-1:0]      CNT_MAX    = {CW{1'b1}};
    localparam logic [CW-1:0]      CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};

    run_state_e         state_r;
    seq_out_t           out_r;
    logic [PRIME_W-1:0] prime_cnt_r;
    logic [CW-1:0]      cycle_cnt_r;

    // Saturating increment so a very long run never wraps back to small counts.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Run FSM with both counters; outputs are registered as the decode of the
    // state being entered, so they always match state_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            out_r       <= moore_out(ST_IDLE);
            prime_cnt_r <= {PRIME_W{1'b0}};
            cycle_cnt_r <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        state_r     <= ST_PRIME;
                        out_r       <= moore_out(ST_PRIME);
                        prime_cnt_r <= PRIME_LOAD;
                        cycle_cnt_r <= {CW{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                        out_r   <= moore_out(ST_IDLE);
                    end
                end
                ST_PRIME: begin
                    if (prime_cnt_r == {PRIME_W{1'b0}}) begin
                        state_r <= ST_RUN;
                        out_r   <= moore_out(ST_RUN);
                    end else begin
                        prime_cnt_r <= prime_cnt_r - {{(PRIME_W-1){1'b0}}, 1'b1};
                        state_r     <= ST_PRIME;
                        out_r       <= moore_out(ST_PRIME);
                    end
                end
                ST_RUN: begin
                    // The halting cycle itself is counted.
                    cycle_cnt_r <= sat_inc(cycle_cnt_r);
                    if (prog_ctr == HALT_VAL) begin
                        state_r <= ST_DONE;
                        out_r   <= moore_out(ST_DONE);
                    end else if (WD_EN && (cycle_cnt_r == WD_LAST)) begin
                        state_r <= ST_FAULT;
                        out_r   <= moore_out(ST_FAULT);
                    end else begin
                        state_r <= ST_RUN;
                        out_r   <= moore_out(ST_RUN);
                    end
                end
                ST_DONE, ST_FAULT: begin
                    // A held request never restarts; it must drop first.
                    if (!req) begin
                        state_r <= ST_IDLE;
                        out_r   <= moore_out(ST_IDLE);
                    end else begin
                        state_r <= state_r;
                        out_r   <= moore_out(state_r);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    out_r   <= moore_out(ST_IDLE);
                end
            endcase
        end
    end

    assign core_reset = out_r.core_reset;
    assign busy       = out_r.busy;
    assign done       = out_r.done;
    assign timeout    = WD_EN & out_r.timeout;
    assign cycle_cnt  = cycle_cnt_r;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed self-checking bench for run_sequencer. DUT a: HALT_PC=128,
// RST_CYCLES=2, WD_LIMIT=20. DUT b: HALT_PC=0, RST_CYCLES=1, CW=4.
module tb_run_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_a, req_b;
    logic [11:0] pc_model_a, pc_model_b, prog_ctr_a, prog_ctr_b;
    logic        core_reset_a, busy_a, done_a, timeout_a;
    logic        core_reset_b, busy_b, done_b, timeout_b;
    logic [15:0] cycle_cnt_a;
    logic [3:0]  cycle_cnt_b;
    int          pc_mode_a;
    int          pc_mode_b;
    int          errors;
    int          checks;

    // PC models: 0 while the core is in reset, +1 per executed cycle.
    always @(posedge clk) begin
        if (core_reset_a) pc_model_a <= 12'd0;
        else              pc_model_a <= pc_model_a + 12'd1;
        if (core_reset_b) pc_model_b <= 12'd0;
        else              pc_model_b <= pc_model_b + 12'd1;
    end

    assign prog_ctr_a = (pc_mode_a == 1) ? 12'd5 :
                        (pc_mode_a == 2) ? pc_model_a + 12'd109 : pc_model_a;
    assign prog_ctr_b = (pc_mode_b == 1) ? 12'd1 : pc_model_b;

    run_sequencer #(.D(12), .HALT_PC(128), .RST_CYCLES(2), .CW(16), .WD_LIMIT(20)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .prog_ctr(prog_ctr_a),
        .core_reset(core_reset_a), .busy(busy_a), .done(done_a),
        .timeout(timeout_a), .cycle_cnt(cycle_cnt_a)
    );

    run_sequencer #(.D(12), .HALT_PC(0), .RST_CYCLES(1), .CW(4), .WD_LIMIT(12)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .prog_ctr(prog_ctr_b),
        .core_reset(core_reset_b), .busy(busy_b), .done(done_b),
        .timeout(timeout_b), .cycle_cnt(cycle_cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
        tick(); tick();
        checks++;
        if ({core_reset_a, busy_a, done_a, timeout_a} !== 4'b1000) begin
            errors++; $display("FAIL reset_out_a: got %b expected 1000", {core_reset_a, busy_a, done_a, timeout_a});
        end
        checks++;
        if (cycle_cnt_a !== 16'd0) begin
            errors++; $display("FAIL reset_cnt_a: got %0d expected 0", cycle_cnt_a);
        end
        checks++;
        if ({core_reset_b, busy_b, done_b, timeout_b, cycle_cnt_b} !== 8'b1000_0000) begin
            errors++; $display("FAIL reset_b: got %b expected 10000000", {core_reset_b, busy_b, done_b, timeout_b, cycle_cnt_b});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({core_reset_a, busy_a, done_a} !== 3'b100) begin
            errors++; $display("FAIL idle_after_reset: got %b expected 100", {core_reset_a, busy_a, done_a});
        end
    endtask

    task automatic test_run_main();
        int low;
        pc_mode_a = 0;
        req_a = 1'b1; tick(); req_a = 1'b0;
        checks++;
        if ({core_reset_a, busy_a, done_a} !== 3'b110) begin
            errors++; $display("FAIL prime_1: got %b expected 110", {core_reset_a, busy_a, done_a});
        end
        tick();
        checks++;
        if ({core_reset_a, busy_a, done_a} !== 3'b110) begin
            errors++; $display("FAIL prime_2: got %b expected 110", {core_reset_a, busy_a, done_a});
        end
        tick();
        checks++;
        if ({core_reset_a, busy_a, done_a, cycle_cnt_a} !== {3'b010, 16'd0}) begin
            errors++; $display("FAIL run_entry: got %b/%0d expected 010/0", {core_reset_a, busy_a, done_a}, cycle_cnt_a);
        end
        low = 1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (core_reset_a) break;
            low++;
        end
        checks++;
        if (low !== 129) begin
            errors++; $display("FAIL run_length: got %0d expected 129", low);
        end
        checks++;
        if ({done_a, busy_a, timeout_a} !== 3'b100) begin
            errors++; $display("FAIL done_rise: got %b expected 100", {done_a, busy_a, timeout_a});
        end
        checks++;
        if (cycle_cnt_a !== 16'd129) begin
            errors++; $display("FAIL cnt_129: got %0d expected 129", cycle_cnt_a);
        end
        tick();
        checks++;
        if ({core_reset_a, busy_a, done_a, cycle_cnt_a} !== {3'b100, 16'd129}) begin
            errors++; $display("FAIL release_hold_cnt: got %b/%0d expected 100/129", {core_reset_a, busy_a, done_a}, cycle_cnt_a);
        end
    endtask

    task automatic test_req_held();
        pc_mode_a = 0;
        req_a = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (done_a) break;
        end
        checks++;
        if (done_a !== 1'b1) begin
            errors++; $display("FAIL held_done: got %b expected 1", done_a);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({core_reset_a, busy_a, done_a} !== 3'b101) begin
                errors++; $display("FAIL held_stay_%0d: got %b expected 101", i, {core_reset_a, busy_a, done_a});
            end
        end
        req_a = 1'b0; tick();
        checks++;
        if ({core_reset_a, busy_a, done_a} !== 3'b100) begin
            errors++; $display("FAIL held_drop: got %b expected 100", {core_reset_a, busy_a, done_a});
        end
        req_a = 1'b1; tick(); req_a = 1'b0;
        checks++;
        if ({busy_a, cycle_cnt_a} !== {1'b1, 16'd0}) begin
            errors++; $display("FAIL restart: got %b/%0d expected 1/0", busy_a, cycle_cnt_a);
        end
        for (int i = 0; i < 400; i++) begin
            tick();
            if (done_a) break;
        end
        tick();
    endtask

    task automatic test_halt_pc_zero();
        pc_mode_b = 0;
        req_b = 1'b1; tick(); req_b = 1'b0;
        checks++;
        if ({core_reset_b, busy_b, done_b} !== 3'b110) begin
            errors++; $display("FAIL b_prime: got %b expected 110", {core_reset_b, busy_b, done_b});
        end
        tick();
        checks++;
        if ({core_reset_b, busy_b, done_b, prog_ctr_b} !== {3'b010, 12'd0}) begin
            errors++; $display("FAIL b_run_pc0: got %b/%0d expected 010/0", {core_reset_b, busy_b, done_b}, prog_ctr_b);
        end
        tick();
        checks++;
        if ({core_reset_b, busy_b, done_b, cycle_cnt_b} !== {3'b101, 4'd1}) begin
            errors++; $display("FAIL b_done_cnt1: got %b/%0d expected 101/1", {core_reset_b, busy_b, done_b}, cycle_cnt_b);
        end
        tick();
        checks++;
        if (done_b !== 1'b0) begin
            errors++; $display("FAIL b_release: got %b expected 0", done_b);
        end
    endtask

    task automatic test_saturation();
        pc_mode_b = 1;
        req_b = 1'b1; tick(); req_b = 1'b0;
        tick();
`ifdef RUN_WATCHDOG_EN
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_b) break;
        end
        checks++;
        if ({timeout_b, done_b, cycle_cnt_b} !== {2'b11, 4'd12}) begin
            errors++; $display("FAIL b_wd: got %b/%0d expected 11/12", {timeout_b, done_b}, cycle_cnt_b);
        end
`else
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if ({core_reset_b, busy_b, done_b, timeout_b, cycle_cnt_b} !== {4'b0100, 4'hF}) begin
            errors++; $display("FAIL b_saturate: got %b/%0d expected 0100/15", {core_reset_b, busy_b, done_b, timeout_b}, cycle_cnt_b);
        end
`endif
        reset = 1'b1; tick(); reset = 1'b0;
        pc_mode_b = 0;
    endtask

    task automatic test_watchdog();
        int low;
        pc_mode_a = 1;
        req_a = 1'b1; tick(); req_a = 1'b0;
        tick(); tick();
        low = 1;
`ifdef RUN_WATCHDOG_EN
        for (int i = 0; i < 100; i++) begin
            tick();
            if (core_reset_a) break;
            low++;
        end
        checks++;
        if (low !== 20) begin
            errors++; $display("FAIL wd_length: got %0d expected 20", low);
        end
        checks++;
        if ({done_a, timeout_a, busy_a, cycle_cnt_a} !== {3'b110, 16'd20}) begin
            errors++; $display("FAIL wd_fault: got %b/%0d expected 110/20", {done_a, timeout_a, busy_a}, cycle_cnt_a);
        end
        tick();
        checks++;
        if ({done_a, timeout_a} !== 2'b00) begin
            errors++; $display("FAIL wd_release: got %b expected 00", {done_a, timeout_a});
        end
`else
        for (int i = 0; i < 1000; i++) tick();
        checks++;
        if ({core_reset_a, busy_a, done_a, timeout_a, cycle_cnt_a} !== {4'b0100, 16'd1000}) begin
            errors++; $display("FAIL no_wd_run: got %b/%0d expected 0100/1000", {core_reset_a, busy_a, done_a, timeout_a}, cycle_cnt_a);
        end
        reset = 1'b1; tick(); reset = 1'b0;
`endif
        pc_mode_a = 0;
    endtask

    task automatic test_halt_coincide();
        int low;
        pc_mode_a = 2;
        req_a = 1'b1; tick(); req_a = 1'b0;
        tick(); tick();
        low = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (core_reset_a) break;
            low++;
        end
        checks++;
        if ({low, done_a, timeout_a, cycle_cnt_a} !== {32'd20, 2'b10, 16'd20}) begin
            errors++; $display("FAIL halt_coincide: got len=%0d done/to=%b cnt=%0d expected 20/10/20", low, {done_a, timeout_a}, cycle_cnt_a);
        end
        tick();
        pc_mode_a = 0;
    endtask

    task automatic test_reset_during_run();
        pc_mode_a = 0;
        req_a = 1'b1; tick(); req_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cycle_cnt_a == 16'd5) break;
        end
        checks++;
        if ({core_reset_a, cycle_cnt_a} !== {1'b0, 16'd5}) begin
            errors++; $display("FAIL mid_run_cnt5: got %b/%0d expected 0/5", core_reset_a, cycle_cnt_a);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++;
        if ({core_reset_a, busy_a, done_a, timeout_a, cycle_cnt_a} !== {4'b1000, 16'd0}) begin
            errors++; $display("FAIL reset_in_run: got %b/%0d expected 1000/0", {core_reset_a, busy_a, done_a, timeout_a}, cycle_cnt_a);
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        pc_mode_a = 0; pc_mode_b = 0;
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
        test_reset();
        test_run_main();
        test_req_held();
        test_halt_pc_zero();
        test_saturation();
        test_watchdog();
        test_halt_coincide();
        test_reset_during_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
